// File: rtl/intc_pkg.sv
// Shared constants and helpers for the intc interrupt controller.
// Register offsets, the VECTOR valid bit position and the fixed-priority encoder.
package intc_pkg;

  localparam int INTC_MAXSRC    = 8;
  localparam int INTC_VALID_BIT = 7;

  typedef enum logic [1:0] {
    INTC_STATUS = 2'd0,
    INTC_MASK   = 2'd1,
    INTC_EDGE   = 2'd2,
    INTC_VECTOR = 2'd3
  } intc_reg_e;

  // Returns {valid, idx[2:0]} for the lowest set bit; index 0 wins.
  function automatic logic [3:0] intc_prio(input logic [INTC_MAXSRC-1:0] req);
    logic [3:0] res;
    res = 4'd0;
    for (int i = INTC_MAXSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        res = {1'b1, 3'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/intc_edge.sv
// Per-source input conditioning: optional 2-flop synchronizer, previous-sample
// flop, and the sampled level / rising-edge outputs.
module intc_edge #(
  parameter bit SYNC = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  output logic s_o,
  output logic rise_o
);

  logic prev_q;

  generate
    if (SYNC) begin : g_sync
      logic [1:0] sync_q;

      // two-stage synchronizer for asynchronous request lines
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_q <= 2'b00;
        end else begin
          sync_q <= {sync_q[0], irq_i};
        end
      end

      assign s_o = sync_q[1];
    end else begin : g_nosync
      assign s_o = irq_i;
    end
  endgenerate

  // previous-cycle sample; not cleared by mode changes so no spurious edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= s_o;
    end
  end

  assign rise_o = s_o & ~prev_q;

endmodule

// File: rtl/intc.sv
// Eight-source interrupt controller: pending/MASK/EDGE registers, fixed
// priority encoder, 4-byte register window and a registered intr output.
module intc
  import intc_pkg::*;
#(
  parameter int NSRC = 8,
  parameter bit SYNC = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      AD,
  input  logic [7:0]      DI,
  output logic [7:0]      DO,
  input  logic            rw,
  input  logic            cs,
  input  logic [NSRC-1:0] irq_in,
  output logic            intr
);

  localparam logic [INTC_MAXSRC-1:0] IMPL = INTC_MAXSRC'((9'd1 << NSRC) - 9'd1);

  logic [INTC_MAXSRC-1:0] s_s;
  logic [INTC_MAXSRC-1:0] rise_s;

  logic [INTC_MAXSRC-1:0] pend_q, pend_d;
  logic [INTC_MAXSRC-1:0] mask_q, mask_d;
  logic [INTC_MAXSRC-1:0] edge_q, edge_d;
  logic                   intr_q, intr_d;

  logic                   wr_s;
  logic [INTC_MAXSRC-1:0] set_s;
  logic [INTC_MAXSRC-1:0] clr_s;
  logic [INTC_MAXSRC-1:0] newly_edge_s;
  logic [3:0]             prio_s;

  genvar gi;
  generate
    for (gi = 0; gi < INTC_MAXSRC; gi++) begin : g_src
      if (gi < NSRC) begin : g_used
        intc_edge #(.SYNC(SYNC)) u_edge (
          .clk    (clk),
          .rst    (rst),
          .irq_i  (irq_in[gi]),
          .s_o    (s_s[gi]),
          .rise_o (rise_s[gi])
        );
      end else begin : g_unused
        assign s_s[gi]    = 1'b0;
        assign rise_s[gi] = 1'b0;
      end
    end
  endgenerate

  // bus write decode and next-state of the software-visible registers
  always_comb begin
    wr_s   = cs & ~rw;
    mask_d = mask_q;
    edge_d = edge_q;
    set_s  = rise_s;
    clr_s  = 8'h00;
    if (wr_s) begin
      case (AD)
        INTC_STATUS: clr_s  = DI & IMPL;
        INTC_MASK:   mask_d = DI & IMPL;
        INTC_EDGE:   edge_d = DI & IMPL;
        INTC_VECTOR: set_s  = rise_s | (DI & IMPL);
        default:     mask_d = mask_q;
      endcase
    end else begin
      clr_s = 8'h00;
    end
  end

  // pending: level bits track the input; edge bits set-wins over clear, and a
  // bit freshly switched into edge mode starts cleared
  always_comb begin
    newly_edge_s = edge_d & ~edge_q;
    pend_d = ((edge_d & (set_s | (pend_q & ~clr_s & ~newly_edge_s)))
            | (~edge_d & s_s)) & IMPL;
    intr_d = |(pend_q & mask_q);
  end

  // state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 8'h00;
      mask_q <= 8'h00;
      edge_q <= 8'h00;
      intr_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
      intr_q <= intr_d;
    end
  end

  assign intr   = intr_q;
  assign prio_s = intc_prio(pend_q & mask_q);

  // read mux, side-effect free and independent of cs
  always_comb begin
    DO = 8'h00;
    case (AD)
      INTC_STATUS: DO = pend_q;
      INTC_MASK:   DO = mask_q;
      INTC_EDGE:   DO = edge_q;
      INTC_VECTOR: DO = {prio_s[3], 4'b0000, prio_s[2:0]};
      default:     DO = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_intc.sv
// Self-checking bench for intc: directed test-plan steps followed by random
// traffic compared against a bit-level behavioural model.
module tb_intc;

  logic       clk;
  logic       rst;
  logic [1:0] AD;
  logic [7:0] DI;
  logic       rw;
  logic       cs;
  logic [7:0] irq;
  logic [7:0] do0, do1;
  logic       intr0, intr1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_pend, m_mask, m_edge, m_prev;
  logic       m_intr;

  intc #(.NSRC(8), .SYNC(1'b0)) u_dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(do0),
    .rw(rw), .cs(cs), .irq_in(irq), .intr(intr0)
  );

  intc #(.NSRC(8), .SYNC(1'b1)) u_dut_sync (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(do1),
    .rw(rw), .cs(cs), .irq_in(irq), .intr(intr1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 8'h00; m_mask = 8'h00; m_edge = 8'h00; m_prev = 8'h00; m_intr = 1'b0;
  endtask

  function automatic logic [7:0] model_read(input logic [1:0] a);
    logic [7:0] act;
    act = m_pend & m_mask;
    case (a)
      2'd0: return m_pend;
      2'd1: return m_mask;
      2'd2: return m_edge;
      default: begin
        for (int i = 0; i < 8; i++) begin
          if (act[i]) return 8'h80 | 8'(i);
        end
        return 8'h00;
      end
    endcase
  endfunction

  // One clock edge: advance the model from the inputs present before the edge.
  task automatic tick();
    logic       wr;
    logic [7:0] np, nm, ne;
    @(posedge clk);
    wr = cs && !rw;
    nm = (wr && AD == 2'd1) ? DI : m_mask;
    ne = (wr && AD == 2'd2) ? DI : m_edge;
    for (int i = 0; i < 8; i++) begin
      if (!ne[i]) np[i] = irq[i];
      else if ((irq[i] && !m_prev[i]) || (wr && AD == 2'd3 && DI[i])) np[i] = 1'b1;
      else if (!m_edge[i]) np[i] = 1'b0;
      else if (wr && AD == 2'd0 && DI[i]) np[i] = 1'b0;
      else np[i] = m_pend[i];
    end
    m_intr = (m_pend & m_mask) != 8'h00;
    m_pend = np; m_mask = nm; m_edge = ne; m_prev = irq;
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    tick();
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic rd_const(input string tag, input logic [1:0] a, input logic [7:0] exp);
    AD = a; #1;
    check(tag, do0, exp);
  endtask

  int n0, n1;

  initial begin
    clk = 1'b0; rst = 1'b0; cs = 1'b0; rw = 1'b1; AD = 2'd0; DI = 8'h00; irq = 8'h00;
    model_reset();
    #12 rst = 1'b1;

    // reset state
    for (int a = 0; a < 4; a++) rd_const("reset_rd", 2'(a), 8'h00);
    check("reset_intr", {7'b0, intr0}, 8'h00);

    // edge mode, source 0
    bus_wr(2'd1, 8'h01);
    bus_wr(2'd2, 8'h01);
    irq = 8'h01; tick(); irq = 8'h00;
    rd_const("edge0_status", 2'd0, 8'h01);
    check("edge0_intr_lag", {7'b0, intr0}, 8'h00);
    tick();
    check("edge0_intr", {7'b0, intr0}, 8'h01);
    rd_const("edge0_vector", 2'd3, 8'h80);
    bus_wr(2'd0, 8'h01);
    rd_const("edge0_cleared", 2'd0, 8'h00);
    tick();
    check("edge0_intr_fall", {7'b0, intr0}, 8'h00);

    // priority
    bus_wr(2'd1, 8'hFF);
    bus_wr(2'd2, 8'hFF);
    irq = 8'h24; tick(); irq = 8'h00; tick();
    rd_const("prio_vec_2", 2'd3, 8'h82);
    bus_wr(2'd0, 8'h04);
    rd_const("prio_vec_5", 2'd3, 8'h85);
    bus_wr(2'd0, 8'h20);
    rd_const("prio_vec_none", 2'd3, 8'h00);

    // level mode
    bus_wr(2'd2, 8'h00);
    bus_wr(2'd1, 8'h02);
    irq = 8'h02; tick(); tick();
    check("level_intr", {7'b0, intr0}, 8'h01);
    bus_wr(2'd0, 8'h02);
    rd_const("level_no_w1c", 2'd0, 8'h02);
    tick();
    check("level_intr_held", {7'b0, intr0}, 8'h01);
    irq = 8'h00; tick();
    check("level_fall_1", {7'b0, intr0}, 8'h01);
    tick();
    check("level_fall_2", {7'b0, intr0}, 8'h00);
    irq = 8'h10; tick(); tick();
    rd_const("masked_status", 2'd0, 8'h10);
    check("masked_intr", {7'b0, intr0}, 8'h00);
    irq = 8'h00; tick();

    // collision: rising edge and STATUS clear in the same cycle
    bus_wr(2'd2, 8'h08);
    bus_wr(2'd1, 8'h08);
    irq = 8'h08;
    bus_wr(2'd0, 8'h08);
    rd_const("collide_status", 2'd0, 8'h08);
    tick();
    check("collide_intr", {7'b0, intr0}, 8'h01);
    irq = 8'h00;

    // asynchronous reset between edges
    @(negedge clk); #1;
    rst = 1'b0; #1;
    model_reset();
    check("async_intr", {7'b0, intr0}, 8'h00);
    rd_const("async_status", 2'd0, 8'h00);
    rd_const("async_mask", 2'd1, 8'h00);
    rst = 1'b1;

    // latency SYNC=0 vs SYNC=1
    bus_wr(2'd1, 8'h40);
    bus_wr(2'd2, 8'h40);
    irq = 8'h40;
    n0 = -1; n1 = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (intr0 && n0 < 0) n0 = k;
      if (intr1 && n1 < 0) n1 = k;
    end
    check("lat_sync0", 8'(n0), 8'd2);
    check("lat_sync1", 8'(n1), 8'd4);
    irq = 8'h00;
    bus_wr(2'd0, 8'h40);
    tick();

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      irq = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        cs = 1'b1; rw = 1'b0; AD = 2'($urandom); DI = 8'($urandom);
      end else begin
        cs = $urandom_range(0, 1) == 1; rw = 1'b1; AD = 2'($urandom); DI = 8'($urandom);
      end
      tick();
      cs = 1'b0; rw = 1'b1;
      check("rand_intr", {7'b0, intr0}, {7'b0, m_intr});
      AD = 2'($urandom); #1;
      check("rand_rd", do0, model_read(AD));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
